// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Sequential load/store controller between the EXU and a
//            handshaked memory port. Accepts one request at a time, builds
//            byte-lane masks and lane-shifted write data, splits accesses
//            that cross a bus word into two beats, and aligns and extends
//            read data. Illegal size codes get an error response without
//            any memory traffic.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            req_valid/req_ready/req_we/req_addr/req_type/req_wdata
//                                          - request from the EXU
//            mem_valid/mem_ready/mem_we/mem_addr/mem_wdata/mem_wmask
//                                          - memory beat request
//            mem_rvalid/mem_rdata          - per-beat response / write ack
//            resp_valid/resp_ready/resp_rdata/resp_err
//                                          - response to the EXU
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [2:0]             req_type,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [8*BUS_BYTES-1:0] mem_wdata,
    output logic [BUS_BYTES-1:0]   mem_wmask,
    input  logic                   mem_rvalid,
    input  logic [8*BUS_BYTES-1:0] mem_rdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [XLEN-1:0]        resp_rdata,
    output logic                   resp_err
);

    localparam int c_off_w  = $clog2(BUS_BYTES);
    localparam int c_bus_w  = 8 * BUS_BYTES;
    localparam int c_win_w  = 2 * c_bus_w;
    localparam int c_mask_w = 2 * BUS_BYTES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_req_ready;
    logic                   r_mem_valid;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [c_bus_w-1:0]     r_mem_wdata;
    logic [BUS_BYTES-1:0]   r_mem_wmask;
    logic                   r_resp_valid;
    logic [XLEN-1:0]        r_resp_rdata;
    logic                   r_resp_err;

    // Latched request context
    logic                   r_we;
    logic [2:0]             r_type;
    logic [c_off_w-1:0]     r_off;
    logic                   r_split;
    logic                   r_beat;
    logic [ADDR_W-1:0]      r_base;
    logic [c_bus_w-1:0]     r_wdata_hi;
    logic [BUS_BYTES-1:0]   r_wmask_hi;
    logic [c_bus_w-1:0]     r_slot0;

    // Request decode (used only on the accepting cycle)
    logic                   w_accept;
    logic [c_off_w-1:0]     w_req_off;
    logic [4:0]             w_req_size;
    logic                   w_req_illegal;
    logic                   w_req_split;
    logic [ADDR_W-1:0]      w_req_base;
    logic [c_win_w-1:0]     w_win_data;
    logic [c_mask_w-1:0]    w_win_mask;

    // Load data alignment
    logic [c_win_w-1:0]     w_rd_window;
    logic [XLEN-1:0]        w_rd_raw;
    logic [7:0]             w_ext_sh;
    logic [XLEN-1:0]        w_rd_left;
    logic [XLEN-1:0]        w_rd_ext;

    assign w_accept      = req_valid & r_req_ready;
    assign w_req_off     = req_addr[c_off_w-1:0];
    assign w_req_size    = 5'd1 << req_type[1:0];
    assign w_req_illegal = (req_type == 3'b111) || (w_req_size > 5'(XLEN / 8));
    assign w_req_split   = (32'(w_req_off) + 32'(w_req_size)) > 32'(BUS_BYTES);
    assign w_req_base    = {req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};

    // Two-word lane window: low half feeds beat 0, high half feeds beat 1.
    // Loads keep both data and mask at zero.
    assign w_win_data = req_we ? (c_win_w'(req_wdata) << {w_req_off, 3'b000}) : '0;
    assign w_win_mask = req_we ?
        (((c_mask_w'(1) << w_req_size) - c_mask_w'(1)) << w_req_off) : '0;

    // For a split load the current beat is the upper slot; otherwise the
    // upper slot is unused because the access fits in one word.
    assign w_rd_window = r_beat ? {mem_rdata, r_slot0} : {{c_bus_w{1'b0}}, mem_rdata};
    assign w_rd_raw    = XLEN'(w_rd_window >> {r_off, 3'b000});

    // Extension by pushing the access to the top of the word and shifting
    // back down, arithmetically for signed types. Shift of 0 is pass-through.
    assign w_ext_sh  = 8'(XLEN) - (8'd8 << r_type[1:0]);
    assign w_rd_left = w_rd_raw << w_ext_sh;
    assign w_rd_ext  = r_type[2] ? (w_rd_left >> w_ext_sh)
                                 : $unsigned($signed(w_rd_left) >>> w_ext_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_we         <= 1'b0;
            r_type       <= '0;
            r_off        <= '0;
            r_split      <= 1'b0;
            r_beat       <= 1'b0;
            r_base       <= '0;
            r_wdata_hi   <= '0;
            r_wmask_hi   <= '0;
            r_slot0      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_type      <= req_type;
                        r_off       <= w_req_off;
                        r_split     <= w_req_split;
                        r_beat      <= 1'b0;
                        r_base      <= w_req_base;
                        r_wdata_hi  <= w_win_data[c_win_w-1:c_bus_w];
                        r_wmask_hi  <= w_win_mask[c_mask_w-1:BUS_BYTES];
                        if (w_req_illegal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= w_req_base;
                            r_mem_wdata <= w_win_data[c_bus_w-1:0];
                            r_mem_wmask <= w_win_mask[BUS_BYTES-1:0];
                            r_resp_err  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_split && !r_beat) begin
                            r_slot0     <= mem_rdata;
                            r_beat      <= 1'b1;
                            r_state     <= S_ISSUE;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= r_base + ADDR_W'(BUS_BYTES);
                            r_mem_wdata <= r_wdata_hi;
                            r_mem_wmask <= r_wmask_hi;
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= r_we ? '0 : w_rd_ext;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_valid  = r_mem_valid;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wmask  = r_mem_wmask;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl. The bench acts as the
//            memory, keeps a byte-addressed reference memory, and predicts
//            beat addresses, byte enables, lane data and load results from
//            byte-level access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr;
    logic [2:0]  req_type;
    logic [63:0] req_wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    lsu_mem_ctrl #(.XLEN(64), .ADDR_W(64), .BUS_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [logic [63:0]];   // memory as written by the DUT
    logic [7:0] ref_mem [logic [63:0]];   // expected memory contents

    logic [63:0] last_rdata, last_addr0, last_addr1, last_wdata0, last_wdata1;
    logic [7:0]  last_mask0, last_mask1;
    logic        last_err;
    int          last_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic preload(input logic [63:0] a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    // Little-endian gather of the accessed bytes, then extension by type.
    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [2:0] typ);
        int          size;
        logic [63:0] v;
        size = 1 << typ[1:0];
        v    = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_rd(addr + 64'(i));
        if (!typ[2] && size < 8 && v[8*size-1])
            for (int j = size; j < 8; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    // One complete request with the bench acting as memory.
    task automatic run_req(input logic we, input logic [63:0] addr, input logic [2:0] typ,
                           input logic [63:0] wdata, input int stall, input int rdly,
                           input int hold, input string tag);
        int          size, off, nb, acc, n;
        logic        eerr;
        logic [63:0] eaddr [2];
        logic [7:0]  emask [2];
        logic [63:0] edata [2];
        logic [63:0] erd, lane, baddr;

        // Reference prediction
        eerr = (typ == 3'b111);
        size = 1 << typ[1:0];
        off  = int'(addr[2:0]);
        nb   = 1;
        for (int b = 0; b < 2; b++) begin
            eaddr[b] = '0; emask[b] = '0; edata[b] = '0;
        end
        erd = '0;
        if (!eerr) begin
            for (int i = 0; i < size; i++) begin
                logic [63:0] a;
                int          b;
                a = addr + 64'(i);
                b = (off + i) / 8;
                if (b == 1) nb = 2;
                eaddr[b] = a & ~64'h7;
                if (we) begin
                    emask[b][a[2:0]] = 1'b1;
                    edata[b][8*int'(a[2:0]) +: 8] = wdata[8*i +: 8];
                end
            end
            if (we) for (int i = 0; i < size; i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
            else    erd = ref_load(addr, typ);
        end
        if (eaddr[1] == 64'h0 && nb == 1) eaddr[1] = eaddr[0];

        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_type = typ; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;

        if (eerr) begin
            check({tag, "_no_beat"}, 64'(mem_valid), 64'd0);
        end else begin
            for (int b = 0; b < nb; b++) begin
                n = 0;
                while (!mem_valid && n < 30) begin @(negedge clk); n++; end
                if (!mem_valid) begin timeout({tag, "_beat_wait"}); return; end
                check({tag, "_addr"}, mem_addr, eaddr[b]);
                check({tag, "_we"}, 64'(mem_we), 64'(we));
                check({tag, "_mask"}, 64'(mem_wmask), 64'(emask[b]));
                for (int k = 0; k < 8; k++) lane[8*k +: 8] = {8{emask[b][k]}};
                check({tag, "_wdata"}, mem_wdata & lane, edata[b]);
                if (b == 0) begin last_addr0 = mem_addr; last_mask0 = mem_wmask; last_wdata0 = mem_wdata; end
                else        begin last_addr1 = mem_addr; last_mask1 = mem_wmask; last_wdata1 = mem_wdata; end
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check({tag, "_stall_valid"}, 64'(mem_valid), 64'd1);
                    check({tag, "_stall_addr"}, mem_addr, eaddr[b]);
                    check({tag, "_stall_mask"}, 64'(mem_wmask), 64'(emask[b]));
                    check({tag, "_stall_wdata"}, mem_wdata & lane, edata[b]);
                end
                baddr = mem_addr;
                if (mem_we)
                    for (int k = 0; k < 8; k++)
                        if (mem_wmask[k]) mem[mem_addr + 64'(k)] = mem_wdata[8*k +: 8];
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                check({tag, "_valid_drop"}, 64'(mem_valid), 64'd0);
                for (int d = 0; d < rdly; d++) @(negedge clk);
                mem_rvalid = 1'b1;
                for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = mem_rd(baddr + 64'(k));
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = {$urandom, $urandom};
            end
        end

        n = 0;
        while (!resp_valid && n < 30) begin @(negedge clk); n++; end
        if (!resp_valid) begin timeout({tag, "_resp_wait"}); return; end
        last_lat   = cyc - acc + 1;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        check({tag, "_rdata"}, resp_rdata, erd);
        check({tag, "_err"}, 64'(resp_err), 64'(eerr));
        if (stall == 0 && rdly == 0)
            check({tag, "_latency"}, 64'(last_lat), eerr ? 64'd1 : (nb == 2 ? 64'd5 : 64'd3));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, resp_rdata, erd);
            check({tag, "_hold_err"}, 64'(resp_err), 64'(eerr));
            check({tag, "_hold_no_beat"}, 64'(mem_valid), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_resp_drop"}, 64'(resp_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_type = '0;
        req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // lw at 0x80000004 from word 0xDEADBEEF_12345678
        for (int k = 0; k < 8; k++) begin
            logic [63:0] w;
            w = 64'hDEADBEEF_12345678;
            preload(64'h8000_0000 + 64'(k), w[8*k +: 8]);
        end
        run_req(1'b0, 64'h8000_0004, 3'b010, '0, 0, 0, 0, "lw");
        check("lw_const_rdata", last_rdata, 64'hFFFFFFFF_DEADBEEF);
        check("lw_const_addr", last_addr0, 64'h8000_0000);
        check("lw_const_lat", 64'(last_lat), 64'd3);

        // Split lhu at 0x80000007
        preload(64'h8000_0007, 8'h34);
        preload(64'h8000_0008, 8'h12);
        run_req(1'b0, 64'h8000_0007, 3'b101, '0, 0, 0, 0, "lhu");
        check("lhu_const_rdata", last_rdata, 64'h1234);
        check("lhu_const_addr0", last_addr0, 64'h8000_0000);
        check("lhu_const_addr1", last_addr1, 64'h8000_0008);
        check("lhu_const_lat", 64'(last_lat), 64'd5);

        // Split sd at 0x80000003
        run_req(1'b1, 64'h8000_0003, 3'b011, 64'h1122334455667788, 0, 0, 0, "sd");
        check("sd_const_mask0", 64'(last_mask0), 64'hF8);
        check("sd_const_mask1", 64'(last_mask1), 64'h07);
        check("sd_const_lanes0", 64'(last_wdata0[63:24]), 64'h44_5566_7788);
        check("sd_const_lanes1", 64'(last_wdata1[23:0]), 64'h11_2233);
        check("sd_const_rdata", last_rdata, 64'd0);
        run_req(1'b0, 64'h8000_0003, 3'b011, '0, 0, 0, 0, "ld_back");
        check("ld_back_const", last_rdata, 64'h1122334455667788);

        // Illegal type, response held for 4 cycles
        run_req(1'b0, 64'h8000_0010, 3'b111, '0, 0, 0, 4, "illegal");
        check("illegal_const_err", 64'(last_err), 64'd1);
        check("illegal_const_lat", 64'(last_lat), 64'd1);

        // Memory stalls on a split access
        run_req(1'b0, 64'h8000_0006, 3'b010, '0, 3, 5, 0, "stall_lw");
        run_req(1'b1, 64'h8000_0005, 3'b010, 64'hCAFEF00D, 3, 5, 0, "stall_sw");

        // Spurious mem_rvalid while idle
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0BAD0BAD0BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("spurious_resp_valid", 64'(resp_valid), 64'd0);
        check("spurious_mem_valid", 64'(mem_valid), 64'd0);
        check("spurious_req_ready", 64'(req_ready), 64'd1);
        run_req(1'b0, 64'h8000_0004, 3'b110, '0, 0, 0, 0, "after_spurious");

        // Reset during WAIT of beat 1
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h2007; req_type = 3'b101;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_beat0", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0102030405060708;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstmid_beat1", 64'(mem_valid), 64'd1);
        check("rstmid_beat1_addr", mem_addr, 64'h2008);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rstmid_in_wait", 64'(mem_valid), 64'd0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_resp", 64'(resp_valid), 64'd0);
        check("late_rvalid_ready", 64'(req_ready), 64'd1);
        run_req(1'b0, 64'h2007, 3'b001, '0, 0, 0, 0, "after_rst");

        // Address wrap on the second beat
        run_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 64'hA1B2C3D4, 0, 0, 0, "wrap_sw");
        check("wrap_const_addr1", last_addr1, 64'h0);
        run_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, '0, 0, 0, 0, "wrap_lw");
        check("wrap_const_rdata", last_rdata, 64'hFFFFFFFF_A1B2C3D4);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [63:0] a;
            logic [2:0]  t;
            int          st, rd;
            t  = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                              : 64'h1000 + 64'($urandom_range(0, 31));
            st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            rd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_req(1'($urandom_range(0, 1)), a, t, {$urandom, $urandom}, st, rd,
                    int'($urandom_range(0, 1)), "rand");
        end

        foreach (ref_mem[k]) check("mem_image", 64'(mem_rd(k)), 64'(ref_mem[k]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
